// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, default width and the divide-by-zero quotient pattern.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    localparam logic [MDU_WIDTH-1:0] DIV0_LO = '1;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation; yields operand magnitudes at Start
// and restores result signs at FIX.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the Hi/Lo registers.
// Optional macro MDU_EARLY_OUT_EN: zero operand skips CALC (FIX at E0+1).
module mult_div_unit import mdu_pkg::*; #(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] MoveData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e         state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               is_div, dbz_r, neg_res, neg_rem;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;

    // Start-time decode
    logic             div_in, signed_in, a_neg, b_neg, b_zero, early;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign div_in    = (Op == OP_DIV) || (Op == OP_DIVU);
    assign signed_in = (Op == OP_MULT) || (Op == OP_DIV);
    assign a_neg     = signed_in & SrcA[WIDTH-1];
    assign b_neg     = signed_in & SrcB[WIDTH-1];
    assign b_zero    = (SrcB == '0);

`ifdef MDU_EARLY_OUT_EN
    assign early = (SrcA == '0) || b_zero;
`else
    assign early = 1'b0;
`endif

    mdu_sign_fix #(.W(WIDTH)) u_abs_a (.val(SrcA), .neg(a_neg), .res(a_abs));
    mdu_sign_fix #(.W(WIDTH)) u_abs_b (.val(SrcB), .neg(b_neg), .res(b_abs));

    // Iteration step; opnd is the multiplicand for MUL, the divisor for DIV
    logic [WIDTH:0]     add_sum, shl, diff;
    logic [2*WIDTH-1:0] mul_step, div_step;

    assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    assign shl      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff     = shl - {1'b0, opnd};
    assign mul_step = acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    // Remainder stays below the divisor, so diff[WIDTH] is a clean borrow flag
    assign div_step = diff[WIDTH] ? {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (.val(acc), .neg(neg_res), .res(prod_fix));
    mdu_sign_fix #(.W(WIDTH))   u_fix_quo  (.val(acc[WIDTH-1:0]), .neg(neg_res), .res(quo_fix));
    mdu_sign_fix #(.W(WIDTH))   u_fix_rem  (.val(acc[2*WIDTH-1:WIDTH]), .neg(neg_rem), .res(rem_fix));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = early ? FIX : CALC;
            CALC:    if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt       <= '0;
            is_div    <= 1'b0;
            dbz_r     <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            opnd      <= '0;
            acc       <= '0;
            Done      <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            DivByZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (HiWrite) Hi <= MoveData;
                    if (LoWrite) Lo <= MoveData;
                    if (Start) begin
                        is_div    <= div_in;
                        dbz_r     <= div_in & b_zero;
                        neg_res   <= a_neg ^ b_neg;
                        neg_rem   <= a_neg;
                        DivByZero <= 1'b0;
                        cnt       <= '0;
                        opnd      <= div_in ? b_abs : a_abs;
                        // Divide by zero freezes acc so FIX restores SrcA into Hi
                        if (div_in && b_zero) acc <= {a_abs, {WIDTH{1'b0}}};
                        else if (early)       acc <= '0;
                        else                  acc <= {{WIDTH{1'b0}}, div_in ? a_abs : b_abs};
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (!dbz_r) acc <= is_div ? div_step : mul_step;
                end
                FIX: begin
                    Done <= 1'b1;
                    if (is_div) begin
                        Hi        <= rem_fix;
                        Lo        <= dbz_r ? WIDTH'(DIV0_LO) : quo_fix;
                        DivByZero <= dbz_r;
                    end else begin
                        {Hi, Lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
